// File: rtl/hazard_flow_ctrl_if.sv
// hazard_flow_ctrl_if: hazard inputs and flow-control outputs between decode and the flow controller.
// Optional HAZ_STALL_CNT_EN adds the stall_cycles counter output.
`default_nettype none

interface hazard_flow_ctrl_if #(
    parameter int REG_ADDR_W = 2
);
    logic [REG_ADDR_W-1:0] id_rs_a;
    logic [REG_ADDR_W-1:0] id_rs_b;
    logic                  id_uses_a;
    logic                  id_uses_b;
    logic                  id_jump;
    logic                  id_halt;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mem_read;
    logic                  ex_branch_taken;
    logic                  mem_busy;
    logic                  int_req;

    logic                  pc_write_en;
    logic                  ifid_write_en;
    logic                  ifid_flush;
    logic                  idex_flush;
    logic [1:0]            pc_sel;
    logic                  int_ack;
    logic                  halted;
`ifdef HAZ_STALL_CNT_EN
    logic [15:0]           stall_cycles;
`endif

    modport master (
        output id_rs_a, id_rs_b, id_uses_a, id_uses_b, id_jump, id_halt,
        output ex_rd, ex_mem_read, ex_branch_taken, mem_busy, int_req,
        input  pc_write_en, ifid_write_en, ifid_flush, idex_flush, pc_sel, int_ack, halted
`ifdef HAZ_STALL_CNT_EN
        , input stall_cycles
`endif
    );

    modport slave (
        input  id_rs_a, id_rs_b, id_uses_a, id_uses_b, id_jump, id_halt,
        input  ex_rd, ex_mem_read, ex_branch_taken, mem_busy, int_req,
        output pc_write_en, ifid_write_en, ifid_flush, idex_flush, pc_sel, int_ack, halted
`ifdef HAZ_STALL_CNT_EN
        , output stall_cycles
`endif
    );
endinterface

`default_nettype wire

// File: rtl/hazard_flow_ctrl.sv
// hazard_flow_ctrl: PC / IF-ID / ID-EX flow sequencing for the 8-bit core.
// Optional macro HAZ_STALL_CNT_EN enables a saturating 16-bit stall cycle counter.
`default_nettype none

module hazard_flow_ctrl #(
    parameter int REG_ADDR_W   = 2,
    parameter int INT_SEQ_LEN  = 3,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    hazard_flow_ctrl_if.slave hz
);
    localparam int MAX_CNT = (INT_SEQ_LEN > DRAIN_CYCLES) ? INT_SEQ_LEN : DRAIN_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] INT_LOAD   = CNT_W'(INT_SEQ_LEN - 2);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_INT_ENTRY = 2'd1,
        S_DRAIN     = 2'd2,
        S_HALT      = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [REG_ADDR_W-1:0] w_ex_rd;
    logic                  w_load_use;
    logic                  w_pc_we, w_ifid_we, w_ifid_fl, w_idex_fl, w_ack, w_halted;
    logic [1:0]            w_pc_sel;

    assign w_ex_rd    = hz.ex_rd;
    assign w_load_use = hz.ex_mem_read &&
                        ((hz.id_uses_a && (hz.id_rs_a == w_ex_rd)) ||
                         (hz.id_uses_b && (hz.id_rs_b == w_ex_rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_pc_we   = 1'b1;
        w_ifid_we = 1'b1;
        w_ifid_fl = 1'b0;
        w_idex_fl = 1'b0;
        w_pc_sel  = 2'b00;
        w_ack     = 1'b0;
        w_halted  = 1'b0;

        if (!rst_n) begin
            // Held in reset: freeze PC/IF-ID and keep bubbles flowing into the pipe.
            w_pc_we   = 1'b0;
            w_ifid_we = 1'b0;
            w_ifid_fl = 1'b1;
            w_idex_fl = 1'b1;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (hz.mem_busy) begin
                        w_pc_we   = 1'b0;
                        w_ifid_we = 1'b0;
                    end else if (hz.ex_branch_taken) begin
                        w_pc_sel  = 2'b10;
                        w_ifid_fl = 1'b1;
                        w_idex_fl = 1'b1;
                    end else if (w_load_use) begin
                        w_pc_we   = 1'b0;
                        w_ifid_we = 1'b0;
                        w_idex_fl = 1'b1;
                    end else if (hz.id_jump) begin
                        w_pc_sel  = 2'b01;
                        w_ifid_fl = 1'b1;
                    end else if (hz.id_halt) begin
                        w_pc_we   = 1'b0;
                        w_ifid_fl = 1'b1;
                        state_d   = S_DRAIN;
                        cnt_d     = DRAIN_LOAD;
                    end else if (hz.int_req) begin
                        w_pc_we   = 1'b0;
                        w_ifid_fl = 1'b1;
                        state_d   = S_INT_ENTRY;
                        cnt_d     = INT_LOAD;
                    end
                end
                S_INT_ENTRY: begin
                    if (hz.mem_busy) begin
                        w_pc_we   = 1'b0;
                        w_ifid_we = 1'b0;
                    end else begin
                        w_pc_we   = 1'b0;
                        w_ifid_fl = 1'b1;
                        w_idex_fl = 1'b1;
                        if (cnt_q == '0) begin
                            w_pc_sel = 2'b11;
                            w_pc_we  = 1'b1;
                            w_ack    = 1'b1;
                            state_d  = S_RUN;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (hz.mem_busy) begin
                        w_pc_we   = 1'b0;
                        w_ifid_we = 1'b0;
                    end else begin
                        w_pc_we   = 1'b0;
                        w_ifid_fl = 1'b1;
                        w_idex_fl = 1'b1;
                        if (cnt_q == '0) begin
                            state_d = S_HALT;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    w_halted  = 1'b1;
                    w_pc_we   = 1'b0;
                    w_ifid_fl = 1'b1;
                    w_idex_fl = 1'b1;
                    if (hz.int_req) begin
                        state_d = S_INT_ENTRY;
                        cnt_d   = INT_LOAD;
                    end
                end
            endcase
        end
    end

    assign hz.pc_write_en   = w_pc_we;
    assign hz.ifid_write_en = w_ifid_we;
    assign hz.ifid_flush    = w_ifid_fl;
    assign hz.idex_flush    = w_idex_fl;
    assign hz.pc_sel        = w_pc_sel;
    assign hz.int_ack       = w_ack;
    assign hz.halted        = w_halted;

`ifdef HAZ_STALL_CNT_EN
    logic [15:0] stall_q;

    // Halted time is idle, not stall, so it is excluded from the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'h0000;
        end else if (!w_pc_we && (state_q != S_HALT) && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'h0001;
        end
    end

    assign hz.stall_cycles = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_flow_ctrl.sv
// tb_hazard_flow_ctrl: directed checks of hazard_flow_ctrl with INT_SEQ_LEN=3, DRAIN_CYCLES=3.
`default_nettype none

module tb_hazard_flow_ctrl;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    hazard_flow_ctrl_if #(.REG_ADDR_W(2)) bus ();

    hazard_flow_ctrl #(
        .REG_ADDR_W  (2),
        .INT_SEQ_LEN (3),
        .DRAIN_CYCLES(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write_en, ifid_write_en, ifid_flush, idex_flush, pc_sel[1:0], int_ack, halted}
    wire [7:0] w_obs = {bus.pc_write_en, bus.ifid_write_en, bus.ifid_flush, bus.idex_flush,
                        bus.pc_sel, bus.int_ack, bus.halted};

    localparam logic [7:0] E_DEF   = 8'b1100_0000;
    localparam logic [7:0] E_RST   = 8'b0011_0000;
    localparam logic [7:0] E_LDUSE = 8'b0001_0000;
    localparam logic [7:0] E_BR    = 8'b1111_1000;
    localparam logic [7:0] E_JMP   = 8'b1110_0100;
    localparam logic [7:0] E_BUSY  = 8'b0000_0000;
    localparam logic [7:0] E_ENTER = 8'b0110_0000;
    localparam logic [7:0] E_SEQ   = 8'b0111_0000;
    localparam logic [7:0] E_ACK   = 8'b1111_1110;
    localparam logic [7:0] E_HALT  = 8'b0111_0001;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_rs_a = 2'd0; bus.id_rs_b = 2'd0; bus.id_uses_a = 1'b0; bus.id_uses_b = 1'b0;
        bus.id_jump = 1'b0; bus.id_halt = 1'b0; bus.ex_rd = 2'd0; bus.ex_mem_read = 1'b0;
        bus.ex_branch_taken = 1'b0; bus.mem_busy = 1'b0; bus.int_req = 1'b0;
    endtask

    task automatic check(input string tag, input logic [7:0] exp);
        logic [7:0] o;
        #3;
        o = w_obs;
        n_tests++;
        assert (o === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, o, exp);
        end
    endtask

`ifdef HAZ_STALL_CNT_EN
    task automatic check_stall(input string tag, input logic [15:0] exp);
        n_tests++;
        assert (bus.stall_cycles === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, bus.stall_cycles, exp);
        end
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        idle();

        tick(); check("reset_outputs", E_RST);
        tick(); rst_n = 1'b1; check("run_defaults", E_DEF);
`ifdef HAZ_STALL_CNT_EN
        check_stall("stall_after_reset", 16'd0);
`endif

        tick(); bus.ex_mem_read = 1'b1; bus.ex_rd = 2'd2; bus.id_rs_a = 2'd2; bus.id_uses_a = 1'b1;
        check("load_use_a", E_LDUSE);
        tick(); idle(); check("after_load_use", E_DEF);
`ifdef HAZ_STALL_CNT_EN
        check_stall("stall_one", 16'd1);
`endif

        tick(); bus.ex_mem_read = 1'b1; bus.ex_rd = 2'd3; bus.id_rs_a = 2'd1; bus.id_uses_a = 1'b1;
        bus.id_rs_b = 2'd3; bus.id_uses_b = 1'b1;
        check("load_use_b", E_LDUSE);
        tick(); idle(); bus.ex_mem_read = 1'b1; bus.ex_rd = 2'd2; bus.id_rs_a = 2'd2;
        check("load_no_use", E_DEF);
        tick(); idle(); bus.ex_mem_read = 1'b1; bus.ex_rd = 2'd0; bus.id_rs_a = 2'd0; bus.id_uses_a = 1'b1;
        check("load_use_r0", E_LDUSE);

        tick(); idle(); bus.ex_branch_taken = 1'b1; bus.id_jump = 1'b1;
        check("branch_over_jump", E_BR);
        tick(); bus.mem_busy = 1'b1; check("busy_over_branch", E_BUSY);
        tick(); idle(); bus.id_jump = 1'b1; check("jump", E_JMP);
        tick(); idle(); bus.ex_branch_taken = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rd = 2'd1;
        bus.id_rs_a = 2'd1; bus.id_uses_a = 1'b1;
        check("branch_over_load_use", E_BR);
        tick(); bus.ex_branch_taken = 1'b0; bus.id_jump = 1'b1; check("load_use_over_jump", E_LDUSE);

        tick(); idle(); bus.int_req = 1'b1; check("int_t0", E_ENTER);
        tick(); idle(); bus.ex_branch_taken = 1'b1; check("int_t1_ignore_branch", E_SEQ);
        tick(); idle(); check("int_t2_ack", E_ACK);
        tick(); check("int_t3_run", E_DEF);

        tick(); bus.id_halt = 1'b1; check("halt_t0", E_ENTER);
        tick(); idle(); check("drain_t1", E_SEQ);
        tick(); check("drain_t2", E_SEQ);
        tick(); check("drain_t3", E_SEQ);
        tick(); check("halted_t4", E_HALT);
        tick(); check("halted_t5", E_HALT);
        tick(); bus.int_req = 1'b1; check("wake_t6", E_HALT);
        tick(); idle(); check("wake_t7", E_SEQ);
        tick(); check("wake_t8_ack", E_ACK);
        tick(); check("wake_t9_run", E_DEF);

        tick(); bus.int_req = 1'b1; check("busy_int_t0", E_ENTER);
        tick(); idle(); bus.mem_busy = 1'b1; check("busy_int_t1", E_BUSY);
        tick(); check("busy_int_t2", E_BUSY);
        tick(); idle(); check("busy_int_t3", E_SEQ);
        tick(); check("busy_int_t4_ack", E_ACK);
        tick(); check("busy_int_t5_run", E_DEF);

        tick(); bus.int_req = 1'b1; check("rst_int_t0", E_ENTER);
        tick(); idle(); rst_n = 1'b0; check("rst_mid_int", E_RST);
        tick(); check("rst_hold_no_ack", E_RST);
        tick(); rst_n = 1'b1; check("rst_release_run", E_DEF);
`ifdef HAZ_STALL_CNT_EN
        check_stall("stall_after_mid_reset", 16'd0);
`endif
        tick(); check("rst_release_run2", E_DEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/hazard_flow_ctrl.md
Name: hazard_flow_ctrl

Overview:
- Pipeline flow controller for the 8-bit core. Sequences the PC register, the IF/ID register and the ID/EX bubble insertion.
- Each cycle it issues PC write-enable, IF/ID hold and flush, ID/EX bubble and next-PC select, based on load-use hazards, jumps, taken branches, memory wait, HLT and interrupt entry.
- Sits beside decode; all outputs are combinational from the state register and current inputs.

Parameters:
- REG_ADDR_W, 2, register-address width (R0..R3).
- INT_SEQ_LEN, 3, interrupt-entry cycle count, >=2.
- DRAIN_CYCLES, 3, cycles to empty EX/MEM/WB before halt, >=1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs_a  in  REG_ADDR_W  source A of the instruction in ID.
- id_rs_b  in  REG_ADDR_W  source B of the instruction in ID.
- id_uses_a / id_uses_b  in  1 each  source valid.
- id_jump  in  1  unconditional jump decoded in ID.
- id_halt  in  1  HLT decoded in ID.
- ex_rd  in  REG_ADDR_W  destination of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  conditional branch resolved taken in EX.
- mem_busy  in  1  data memory not ready; freeze the whole front end.
- int_req  in  1  level interrupt request.
- pc_write_en  out  1  PC register load enable.
- ifid_write_en  out  1  IF/ID load enable (0 = hold).
- ifid_flush  out  1  IF/ID clear to NOP (0x00).
- idex_flush  out  1  inject bubble into ID/EX.
- pc_sel  out  2  00 PC+1, 01 ID jump target, 10 EX branch target, 11 interrupt vector.
- int_ack  out  1  one-cycle pulse on the vector-load cycle.
- halted  out  1  core halted.

Behaviour:
- Defaults, unless overridden below: pc_write_en=1, ifid_write_en=1, ifid_flush=0, idex_flush=0, pc_sel=00, int_ack=0, halted=0.
- Reset (rst_n=0, asynchronous): state=RUN, cnt=0. While rst_n=0, outputs are forced to pc_write_en=0, ifid_write_en=0, ifid_flush=1, idex_flush=1, pc_sel=00, int_ack=0, halted=0. Reset mid-sequence abandons the sequence with no int_ack.
- States: RUN, INT_ENTRY, DRAIN, HALT. Down-counter cnt, width sized for max(INT_SEQ_LEN, DRAIN_CYCLES).
- RUN, fixed priority, highest first:
  1. mem_busy: pc_write_en=0, ifid_write_en=0, no flushes; all lower events ignored this cycle.
  2. ex_branch_taken: pc_sel=10, ifid_flush=1, idex_flush=1.
  3. Load-use: ex_mem_read && ((id_uses_a && id_rs_a==ex_rd) || (id_uses_b && id_rs_b==ex_rd)). Outputs pc_write_en=0, ifid_write_en=0, idex_flush=1. Lasts exactly 1 cycle; no state change. R0 is not special.
  4. id_jump: pc_sel=01, ifid_flush=1.
  5. id_halt: ifid_flush=1, pc_write_en=0; go to DRAIN with cnt=DRAIN_CYCLES-1.
  6. int_req: pc_write_en=0, ifid_flush=1; go to INT_ENTRY with cnt=INT_SEQ_LEN-2.
- INT_ENTRY:
  - Each cycle: pc_write_en=0, ifid_flush=1, idex_flush=1.
  - When cnt==0: pc_sel=11, pc_write_en=1, int_ack=1, then go to RUN. Total sequence is INT_SEQ_LEN cycles including the RUN entry cycle.
  - int_req, branch, jump and halt are ignored in this state.
- DRAIN:
  - Each cycle: pc_write_en=0, ifid_flush=1, idex_flush=1; cnt decrements.
  - When cnt==0, go to HALT.
- HALT: halted=1, pc_write_en=0, ifid_flush=1, idex_flush=1. On int_req, go to INT_ENTRY with cnt=INT_SEQ_LEN-2; halted drops the next cycle.
- mem_busy in INT_ENTRY or DRAIN: cnt holds, outputs as in the mem_busy row (freeze, no ack), state holds.
- Simultaneous events in RUN resolve strictly by priority. A lower event still asserted next cycle is serviced then. int_req is level-sensitive and is never lost while high.

Optional Feature:
- Macro: HAZ_STALL_CNT_EN.
- Defined: adds output stall_cycles [15:0], reset to 0. Increments, saturating at 0xFFFF, every cycle with pc_write_en=0 while rst_n=1 and the state is not HALT.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=2, id_rs_a=2, id_uses_a=1 for one cycle -> that cycle pc_write_en=0, ifid_write_en=0, idex_flush=1; next cycle (ex_mem_read=0) -> defaults.
- Branch vs jump: ex_branch_taken=1 and id_jump=1 in the same cycle -> pc_sel=10, ifid_flush=1, idex_flush=1. With mem_busy=1 added -> pc_write_en=0, ifid_write_en=0, pc_sel=00, no flushes.
- Interrupt entry, INT_SEQ_LEN=3: int_req pulsed at cycle t -> t and t+1 have pc_write_en=0, ifid_flush=1; t+2 has pc_sel=11, pc_write_en=1, int_ack=1; t+3 is RUN defaults.
- Halt/wake, DRAIN_CYCLES=3: id_halt at t -> halted=1 from t+4. int_req at t+6 -> int_ack at t+8, halted=0 at t+7.
- mem_busy for 2 cycles inside INT_ENTRY -> int_ack is delayed by exactly 2 cycles; no flush or ack while busy.
- rst_n dropped mid-INT_ENTRY -> outputs immediately at reset values, no int_ack. After rst_n rises -> RUN defaults. With HAZ_STALL_CNT_EN, stall_cycles=0 after reset.
